// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC128S022-style SPI master: FSM state
// encoding, frame geometry and the din address-bit selector.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FRAME_BITS     = 16;  // SCLK periods per conversion frame
  localparam int DATA_BITS      = 12;  // sample width, D11..D0
  localparam int LEAD_BITS      = 4;   // zeros the ADC sends ahead of D11
  localparam int ADDR_BITS      = 3;   // channel address width
  localparam int ADDR_FIRST_BIT = 2;   // frame bit carrying the address MSB
  localparam int BIT_CNT_W      = 5;   // must hold FRAME_BITS itself

  // Value to present on din during frame bit idx: the address is sent MSB
  // first in three consecutive bits, every other bit is a don't-care 0.
  function automatic logic addr_bit(input logic [ADDR_BITS-1:0] addr,
                                    input logic [BIT_CNT_W-1:0] idx);
    logic b;
    b = 1'b0;
    if (idx == BIT_CNT_W'(ADDR_FIRST_BIT))
      b = addr[2];
    else if (idx == BIT_CNT_W'(ADDR_FIRST_BIT + 1))
      b = addr[1];
    else if (idx == BIT_CNT_W'(ADDR_FIRST_BIT + 2))
      b = addr[0];
    return b;
  endfunction

endpackage

// File: rtl/adc_spi_sclk_gen.sv
// SCLK generator. While en is high it produces a low half-period followed
// by a high half-period of SCLK_HALF clocks each, repeating. The strobes are
// one clock wide and mark the cycle whose closing edge changes sclk:
//   fall_tick  - sclk goes low on the next edge (start of a period)
//   rise_tick  - sclk goes high on the next edge (middle of a period)
//   period_end - last clock of the high half-period
// With en low the counter is cleared and sclk rests high.
module adc_spi_sclk_gen #(
  parameter int SCLK_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic fall_tick,
  output logic rise_tick,
  output logic period_end
);

  localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);

  logic [7:0] half_cnt;
  logic       phase;     // 0 = low half, 1 = high half

  assign fall_tick  = en & ~phase & (half_cnt == 8'd0);
  assign rise_tick  = en &  phase & (half_cnt == 8'd0);
  assign period_end = en &  phase & (half_cnt == HALF_LAST);

  // Half-period counter; phase flips each time a half-period completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= 8'd0;
      phase    <= 1'b0;
    end else if (!en) begin
      half_cnt <= 8'd0;
      phase    <= 1'b0;
    end else if (half_cnt == HALF_LAST) begin
      half_cnt <= 8'd0;
      phase    <= ~phase;
    end else begin
      half_cnt <= half_cnt + 8'd1;
    end
  end

  // Registered sclk, moved by the strobes so it lines up with din updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk <= 1'b1;
    end else if (!en) begin
      sclk <= 1'b1;
    end else if (fall_tick) begin
      sclk <= 1'b0;
    end else if (rise_tick) begin
      sclk <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_master.sv
// Free-running SPI master for an 8-channel 12-bit serial ADC.
// Each frame: cs low for 16 SCLK periods, the channel address goes out on
// din in bits 2..4, 16 bits come back on ADC2SPI MSB first, and the low 12
// bits are published on ADC2Sseg with a one-clock data_valid pulse.
//
// Optional build macro LEAD_ZERO_CHECK_EN: adds frame_err, and frames whose
// four leading bits are not zero are dropped (no update, no data_valid,
// one-clock frame_err pulse instead).
//
// dbg_state mirrors the FSM state register (IDLE=0, XFER=1, DONE=2).
module adc_spi_master
  import adc_spi_pkg::*;
#(
  parameter int SCLK_HALF = 2,
  parameter int CS_IDLE   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] ADD,
  input  logic                 ADC2SPI,
  output logic                 sclk,
  output logic                 din,
  output logic                 cs,
  output logic [DATA_BITS-1:0] ADC2Sseg,
  output logic                 data_valid,
`ifdef LEAD_ZERO_CHECK_EN
  output logic                 frame_err,
`endif
  output logic [1:0]           dbg_state
);

  localparam logic [7:0] IDLE_LAST = 8'(CS_IDLE - 1);

  state_t                 state;
  logic [7:0]             idle_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt_nxt;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [FRAME_BITS-1:0]  shift_q;
  logic                   fall_tick;
  logic                   rise_tick;
  logic                   period_end;
  logic                   xfer_en;

  assign xfer_en   = (state == XFER);
  assign dbg_state = state;

  // With SCLK_HALF=1 the final rise and the end of the frame fall in the
  // same clock, so the end-of-frame test looks at the post-rise count.
  assign bit_cnt_nxt = bit_cnt + {{(BIT_CNT_W-1){1'b0}}, rise_tick};

`ifndef LEAD_ZERO_CHECK_EN
  // Leading bits are received but deliberately not inspected in this build.
  logic unused_lead;
  assign unused_lead = ^shift_q[FRAME_BITS-1 -: LEAD_BITS];
`endif

  adc_spi_sclk_gen #(
    .SCLK_HALF (SCLK_HALF)
  ) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (xfer_en),
    .sclk       (sclk),
    .fall_tick  (fall_tick),
    .rise_tick  (rise_tick),
    .period_end (period_end)
  );

  // Frame sequencer: idle gap, 16-period transfer, one-clock publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idle_cnt   <= 8'd0;
      bit_cnt    <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      cs         <= 1'b1;
      din        <= 1'b0;
      ADC2Sseg   <= '0;
      data_valid <= 1'b0;
`ifdef LEAD_ZERO_CHECK_EN
      frame_err  <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
`ifdef LEAD_ZERO_CHECK_EN
      frame_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cs  <= 1'b1;
          din <= 1'b0;
          if (idle_cnt == IDLE_LAST) begin
            // Address is frozen here so ADD may change freely mid-frame.
            idle_cnt <= 8'd0;
            addr_q   <= ADD;
            bit_cnt  <= '0;
            cs       <= 1'b0;
            state    <= XFER;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end

        XFER: begin
          if (fall_tick) begin
            din <= addr_bit(addr_q, bit_cnt);
          end
          if (rise_tick) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], ADC2SPI};
          end
          bit_cnt <= bit_cnt_nxt;
          if (period_end && (bit_cnt_nxt == BIT_CNT_W'(FRAME_BITS))) begin
            cs    <= 1'b1;
            din   <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          cs    <= 1'b1;
          din   <= 1'b0;
          state <= IDLE;
`ifdef LEAD_ZERO_CHECK_EN
          if (shift_q[FRAME_BITS-1 -: LEAD_BITS] != '0) begin
            frame_err <= 1'b1;
          end else begin
            ADC2Sseg   <= shift_q[DATA_BITS-1:0];
            data_valid <= 1'b1;
          end
`else
          ADC2Sseg   <= shift_q[DATA_BITS-1:0];
          data_valid <= 1'b1;
`endif
        end

        default: begin
          cs    <= 1'b1;
          din   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master: an ADC model answering on falling sclk, a
// negedge monitor that records din per bit, frame timing and data_valid
// pulses, a sample scoreboard, a vector table and hand-written sequences
// for mid-frame address change, mid-frame reset and leading-bit frames.
`timescale 1ns/1ps
module tb_adc_spi_master;

  localparam int SCLK_HALF  = 2;
  localparam int CS_IDLE    = 4;
  localparam int CS_LOW_CLK = 64;   // 16 periods of 2*SCLK_HALF clocks
  localparam int FRAME_CLK  = 69;   // 64 transfer + 1 publish + 4 idle
  localparam int NVEC       = 10;

  logic        clk;
  logic        rst_n;
  logic [2:0]  ADD;
  logic        ADC2SPI;
  logic        sclk;
  logic        din;
  logic        cs;
  logic [11:0] ADC2Sseg;
  logic        data_valid;
  logic [1:0]  dbg_state;
`ifdef LEAD_ZERO_CHECK_EN
  logic        frame_err;
`endif

  adc_spi_master #(
    .SCLK_HALF (SCLK_HALF),
    .CS_IDLE   (CS_IDLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ADD        (ADD),
    .ADC2SPI    (ADC2SPI),
    .sclk       (sclk),
    .din        (din),
    .cs         (cs),
    .ADC2Sseg   (ADC2Sseg),
    .data_valid (data_valid),
`ifdef LEAD_ZERO_CHECK_EN
    .frame_err  (frame_err),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- ADC model ----------------
  logic [15:0] next_word = 16'h0;
  logic [15:0] cur_word  = 16'h0;
  int          adc_idx   = 0;

  always @(negedge cs) cur_word = next_word;

  always @(posedge cs or negedge sclk) begin
    if (cs) begin
      adc_idx = 0;
      ADC2SPI = 1'b0;
    end else if (adc_idx < 16) begin
      ADC2SPI = cur_word[15 - adc_idx];
      adc_idx++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_dv = 1'b0;
  logic        din_low = 1'b0;
  logic [11:0] prev_seg = 12'h0;
  logic [15:0] din_bits = 16'h0;
  int rise_cnt = 0, n_cs_fall = 0, n_cs_rise = 0;
  int cs_fall_cyc = 0, cs_fall_prev = 0, cs_low_len = 0;
  int n_dv = 0, dv_cyc = 0, dv_prev_cyc = 0, dv_wide = 0;
  int unstable = 0, seg_change_err = 0, n_ferr = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs   = 1'b1;
      prev_sclk = 1'b1;
      prev_dv   = 1'b0;
      prev_seg  = 12'h0;
    end else begin
      if (prev_cs && !cs) begin
        cs_fall_prev = cs_fall_cyc;
        cs_fall_cyc  = cyc;
        rise_cnt     = 0;
        din_bits     = 16'h0;
        n_cs_fall++;
      end
      if (!prev_cs && cs) begin
        cs_low_len = cyc - cs_fall_cyc;
        n_cs_rise++;
      end
      if (!cs && sclk && !prev_sclk) begin
        if (rise_cnt < 16) din_bits[15 - rise_cnt] = din;
        if (din !== din_low) unstable++;
        rise_cnt++;
      end
      if (!cs && !sclk) din_low = din;
      if (!cs && (ADC2Sseg !== prev_seg)) seg_change_err++;
      if (data_valid) begin
        n_dv++;
        dv_prev_cyc = dv_cyc;
        dv_cyc      = cyc;
        if (prev_dv) dv_wide++;
        check("sb_sample_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_sample", 32'(ADC2Sseg), 32'(exp_q.pop_front()));
      end
`ifdef LEAD_ZERO_CHECK_EN
      if (frame_err) n_ferr++;
`endif
      prev_cs   = cs;
      prev_sclk = sclk;
      prev_dv   = data_valid;
      prev_seg  = ADC2Sseg;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cs_fall(input string name, input int base);
    for (int k = 0; k < 400 && n_cs_fall == base; k++) tick();
    check({name, "_cs_fall_seen"}, 32'(n_cs_fall != base), 32'd1);
  endtask

  task automatic wait_cs_rise(input string name, input int base);
    for (int k = 0; k < 400 && n_cs_rise == base; k++) tick();
    check({name, "_cs_rise_seen"}, 32'(n_cs_rise != base), 32'd1);
  endtask

  // Finish a frame already in flight: wait for cs to rise, let the sample
  // publish, then check bit count, din pattern, cs width and sample drain.
  task automatic finish_frame(input string name, input int rise_base,
                              input logic [15:0] exp_din);
    wait_cs_rise(name, rise_base);
    tick();
    tick();
    check({name, "_rises"}, 32'(rise_cnt), 32'd16);
    check({name, "_din"}, 32'(din_bits), 32'(exp_din));
    check({name, "_cs_low"}, 32'(cs_low_len), 32'(CS_LOW_CLK));
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_frame(input string name, input logic [2:0] add,
                          input logic [15:0] word, input logic [15:0] exp_din,
                          input logic [11:0] exp_data, input bit expect_update);
    int falls0, rises0;
    ADD       = add;
    next_word = word;
    if (expect_update) exp_q.push_back(exp_data);
    falls0 = n_cs_fall;
    rises0 = n_cs_rise;
    wait_cs_fall(name, falls0);
    finish_frame(name, rises0, exp_din);
    if (expect_update) check({name, "_seg_hold"}, 32'(ADC2Sseg), 32'(exp_data));
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [2:0]  add;
    logic [15:0] word;
    logic [15:0] exp_din;   // din at bit 0..15, bit 0 in the MSB
    logic [11:0] exp_data;
  } vec_t;

  vec_t vec[NVEC];

  initial begin
    logic [11:0] rnd;
    int falls0, rises0, rel_cyc, ferr0, dv0;

    rnd    = 12'($urandom_range(0, 4095));
    vec[0] = '{3'd5, 16'h0AC5, 16'h2800, 12'hAC5};
    vec[1] = '{3'd5, 16'h0AC5, 16'h2800, 12'hAC5};
    vec[2] = '{3'd5, 16'h0AC5, 16'h2800, 12'hAC5};
    vec[3] = '{3'd2, 16'h0FFF, 16'h1000, 12'hFFF};
    vec[4] = '{3'd7, 16'h0000, 16'h3800, 12'h000};
    vec[5] = '{3'd0, 16'h0555, 16'h0000, 12'h555};
    vec[6] = '{3'd3, 16'h0AAA, 16'h1800, 12'hAAA};
    vec[7] = '{3'd6, 16'h0800, 16'h3000, 12'h800};
    vec[8] = '{3'd1, 16'h0001, 16'h0800, 12'h001};
    vec[9] = '{3'd4, {4'h0, rnd}, 16'h2000, rnd};

    // Reset held for 5 clocks.
    rst_n     = 1'b0;
    ADD       = 3'd0;
    next_word = 16'h0;
    repeat (5) tick();
    check("rst_sclk", 32'(sclk), 32'd1);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_din", 32'(din), 32'd0);
    check("rst_seg", 32'(ADC2Sseg), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    rst_n   = 1'b1;
    rel_cyc = cyc;

    // Table-driven frames; entries 0..2 are back-to-back repeats.
    for (int i = 0; i < NVEC; i++) begin
      do_frame($sformatf("vec%0d", i), vec[i].add, vec[i].word,
               vec[i].exp_din, vec[i].exp_data, 1'b1);
      if (i == 0) check("rst_to_cs_fall", 32'(cs_fall_cyc - rel_cyc), 32'(CS_IDLE));
      if (i > 0 && i < 3) begin
        check($sformatf("vec%0d_cs_period", i), 32'(cs_fall_cyc - cs_fall_prev), 32'(FRAME_CLK));
        check($sformatf("vec%0d_dv_period", i), 32'(dv_cyc - dv_prev_cyc), 32'(FRAME_CLK));
      end
    end

    // ADD changes 5 -> 2 after bit 3 is under way: this frame still sends 101.
    ADD       = 3'd5;
    next_word = 16'h0321;
    exp_q.push_back(12'h321);
    falls0 = n_cs_fall;
    rises0 = n_cs_rise;
    wait_cs_fall("addchg", falls0);
    for (int k = 0; k < 200 && rise_cnt < 3; k++) tick();
    ADD = 3'd2;
    finish_frame("addchg", rises0, 16'h2800);
    do_frame("addchg_next", 3'd2, 16'h0456, 16'h1000, 12'h456, 1'b1);

    // Reset in the middle of bit 8: outputs return to reset values at once.
    ADD       = 3'd5;
    next_word = 16'h0777;
    falls0    = n_cs_fall;
    wait_cs_fall("midrst", falls0);
    for (int k = 0; k < 200 && rise_cnt < 8; k++) tick();
    check("midrst_cs_low_before", 32'(cs), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_cs", 32'(cs), 32'd1);
    check("midrst_seg", 32'(ADC2Sseg), 32'd0);
    check("midrst_sclk", 32'(sclk), 32'd1);
    check("midrst_din", 32'(din), 32'd0);
    repeat (3) tick();
    rst_n   = 1'b1;
    rel_cyc = cyc;
    do_frame("after_rst", 3'd6, 16'h0BEE, 16'h3000, 12'hBEE, 1'b1);
    check("after_rst_cs_fall", 32'(cs_fall_cyc - rel_cyc), 32'(CS_IDLE));

    // Leading bits not zero.
    do_frame("pre_lead", 3'd5, 16'h0AC5, 16'h2800, 12'hAC5, 1'b1);
    dv0 = n_dv;
`ifdef LEAD_ZERO_CHECK_EN
    ferr0 = n_ferr;
    do_frame("lead", 3'd5, 16'h4123, 16'h2800, 12'h123, 1'b0);
    check("lead_seg_kept", 32'(ADC2Sseg), 32'hAC5);
    check("lead_ferr_pulses", 32'(n_ferr - ferr0), 32'd1);
    check("lead_no_dv", 32'(n_dv - dv0), 32'd0);
`else
    ferr0 = 0;
    do_frame("lead", 3'd5, 16'h4123, 16'h2800, 12'h123, 1'b1);
    check("lead_dv", 32'(n_dv - dv0 + ferr0), 32'd1);
`endif

    // Whole-run properties gathered by the monitor.
    check("din_stable_at_rise", 32'(unstable), 32'd0);
    check("seg_static_cs_low", 32'(seg_change_err), 32'd0);
    check("dv_one_clk", 32'(dv_wide), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_spi_master.md
Name: adc_spi_master

Overview:
- SPI master that continuously polls an 8-channel, 12-bit serial ADC (16-SCLK frame, ADC128S022-style protocol).
- Each frame shifts the 3-bit channel address out on din and shifts 16 bits in from ADC2SPI: 4 leading zeros, then D11..D0, MSB first.
- The captured 12-bit sample is held on ADC2Sseg for the seven-segment/display path of the oscilloscope.

Parameters:
- SCLK_HALF, 2: system clocks per SCLK half-period; legal range 1..255.
- CS_IDLE, 4: system clocks cs is held high between frames; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ADD  in  3  ADC channel address.
- ADC2SPI  in  1  serial data from ADC DOUT.
- sclk  out  1  SPI clock to ADC; idles high.
- din  out  1  serial data to ADC DIN.
- cs  out  1  ADC chip select, active low.
- ADC2Sseg  out  12  last captured sample.
- data_valid  out  1  one-clk pulse when ADC2Sseg updates.

Behaviour:
- Reset values: sclk=1, cs=1, din=0, ADC2Sseg=0, data_valid=0, FSM=IDLE, all counters 0.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - cs=1, sclk=1; count CS_IDLE clocks.
  - On expiry: latch ADD into addr_q, set bit_cnt=0, drive cs=0, go to XFER.
  - din = 0 in IDLE.
- XFER (16 SCLK periods):
  - Each period: sclk low for SCLK_HALF clocks, then high for SCLK_HALF clocks.
  - din updates on the clk where sclk falls.
  - din per bit_cnt: 0,1 -> 0; 2 -> addr_q[2]; 3 -> addr_q[1]; 4 -> addr_q[0]; 5..15 -> 0.
  - ADC2SPI sampled on the clk where sclk rises; shifted into a 16-bit shift register, MSB first.
  - bit_cnt increments after each rising edge. After the 16th rising edge, go to DONE.
- DONE (1 clk):
  - ADC2Sseg <= shift[11:0]; data_valid=1 for this clk only.
  - cs=1, sclk=1; go to IDLE.
- Frame timing:
  - Frame length = 32*SCLK_HALF clocks in XFER, plus 1 DONE, plus CS_IDLE.
  - Defaults: 64 + 1 + 4 = 69 clocks per sample.
- ADD changes mid-frame have no effect until the next frame (addr_q latched at cs fall).
- ADC2Sseg holds its value between frames; it never changes while cs is low.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded and ADC2Sseg clears to 0.
- Operation is free-running; no start input. The first frame begins CS_IDLE clocks after rst_n deasserts.
- Leading bits shift[15:12] are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: LEAD_ZERO_CHECK_EN.
- Defined:
  - Adds output frame_err (1 bit, reset 0).
  - In DONE, if shift[15:12] != 0: ADC2Sseg is NOT updated, data_valid stays 0, and frame_err pulses 1 for one clk.
- Undefined:
  - No frame_err port.
  - Every frame updates ADC2Sseg regardless of leading bits.

Decomposition:
- Package adc_spi_pkg holds:
  - FSM state enum (IDLE/XFER/DONE).
  - FRAME_BITS=16, DATA_BITS=12, LEAD_BITS=4.
  - ADDR_FIRST_BIT=2.
- One natural sub-module: adc_spi_sclk_gen.
  - Half-period counter producing sclk plus one-clk fall_tick/rise_tick strobes, enabled only in XFER.
  - The top-level FSM consumes the ticks.

Test Plan:
- Reset: hold rst_n=0 for 5 clks -> sclk=1, cs=1, din=0, ADC2Sseg=0, data_valid=0. Release -> cs falls exactly CS_IDLE=4 clks later.
- Address shift: ADD=3'b101 -> din over bits 0..15 reads 0,0,1,0,1,0,...,0, stable across each sclk rising edge. Exactly 16 sclk rising edges while cs=0.
- Data capture: model ADC drives 0000 then 12'b1010_1100_0101 on falling edges -> after frame, ADC2Sseg=12'hAC5 with a one-clk data_valid pulse. Repeat 3 frames -> same value, 69 clks apart.
- Mid-frame ADD change: ADD 5->2 at bit 3 -> current frame din still encodes 101; next frame encodes 010.
- Mid-frame reset: assert rst_n=0 at bit 8 -> cs=1 and ADC2Sseg=0 immediately; the next full frame captures the new value correctly.
- With LEAD_ZERO_CHECK_EN: leading bits 4'b0100 with data 12'h123 -> ADC2Sseg keeps the previous 12'hAC5, frame_err pulses once, no data_valid.
